if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch pipeline stage that sits directly upstream of the decode stage. It owns the fetch PC and issues one-outstanding-request fetches to instruction memory with a req/rdy handshake. It absorbs variable memory latency, backpressure, and branch/trap redirects. It drives the IF/ID pipeline register (pc, if_pc, if_insn, if_en, if_hart_st) consumed by decode.

Parameters:
RESET_VECTOR, 32'h0000_0000, fetch_pc value after reset.
NOP_INSN, 32'h0000_0013, instruction word loaded into if_insn for bubbles (addi x0,x0,0).
HART_ST_W, 4, width of hart state tag.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address; word aligned.
imem_rdy  input  1  response valid this cycle for the held address.
imem_rd_data  input  32  fetched instruction word.
stall  input  1  hold IF/ID register and fetch progress.
flush  input  1  load bubble into IF/ID.
redirect_en  input  1  branch/jump/trap redirect.
redirect_pc  input  32  redirect target.
hart_st  input  HART_ST_W  current hart state, tagged onto fetched instruction.
fetch_busy  output  1  fetch waiting on memory (to control unit).
pc  output  32  IF/ID: PC of if_insn.
if_pc  output  32  IF/ID: pc+4.
if_insn  output  32  IF/ID: instruction.
if_en  output  1  IF/ID: entry valid.
if_hart_st  output  HART_ST_W  IF/ID: hart state of entry.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset, sampled on the clk edge: state=FETCH, fetch_pc=RESET_VECTOR, pc=0, if_pc=0, if_insn=NOP_INSN, if_en=0, if_hart_st=0, skid empty. imem_req=0 while reset is high; it rises on the first cycle after reset deasserts. Reset mid-request drops the outstanding request silently.
- FSM states:
  - FETCH: imem_req=1, imem_addr=fetch_pc.
  - HOLD: instruction captured in skid, ID stalled; imem_req=0.
  - DROP: stale request outstanding after a redirect; imem_req=1 with the old address held.
- imem_addr and imem_req stay stable until imem_rdy. Only one request is outstanding. Memory latency is 1..N cycles; imem_rdy may be high in the same cycle as imem_req (zero-wait).
- FETCH, imem_rdy=1, stall=0: IF/ID loads pc=fetch_pc, if_pc=fetch_pc+4, if_insn=imem_rd_data, if_en=1, if_hart_st=hart_st. fetch_pc advances by 4. Throughput is one instruction per cycle on zero-wait memory.
- FETCH, imem_rdy=1, stall=1: word, pc, and hart_st go to skid; go to HOLD. IF/ID is unchanged.
- FETCH, imem_rdy=0: if stall=0, IF/ID loads a bubble (if_en=0, if_insn=NOP_INSN, pc/if_pc unchanged). If stall=1, IF/ID is held.
- HOLD, stall=0: IF/ID loads from skid; fetch_pc advances by 4; go to FETCH.
- Redirect:
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - In FETCH with imem_rdy=0: go to DROP. In DROP, imem_rdy causes the data to be discarded and the FSM returns to FETCH using the new fetch_pc.
  - In FETCH with imem_rdy=1 in the same cycle: data is discarded and the FSM stays in FETCH.
  - In HOLD: skid is discarded; go to FETCH.
  - A redirect while in DROP overwrites fetch_pc and stays in DROP.
- flush: IF/ID loads a bubble (if_en=0, if_insn=NOP_INSN). flush overrides stall for IF/ID only; fetch progress still honours stall.
- Priority: reset > redirect_en (fetch_pc/FSM) > stall. Also reset > flush > stall (IF/ID).
- fetch_pc+4 wraps modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.
- fetch_busy = (state==FETCH & !imem_rdy) | (state==DROP).

Test Plan:
- Zero-wait stream: after reset, imem_rdy tied 1 with data=addr^32'hA5A5_0000 -> imem_addr 0,4,8,... on consecutive cycles. IF/ID shows pc=0,if_insn=32'hA5A5_0000,if_en=1 one cycle after the first request, then increments by 4 every cycle.
- 3-cycle memory latency -> imem_addr held constant for 3 cycles, fetch_busy=1 for 2 cycles, if_en=0 bubbles between valid entries.
- stall asserted in the cycle imem_rdy returns word 32'h0050_0093 at pc=8 -> HOLD, imem_req=0, IF/ID frozen. On stall release, IF/ID gets pc=8, if_insn=32'h0050_0093 and imem_addr=12 next.
- redirect_en with redirect_pc=32'h0000_0103 while a request to 0x10 is pending -> DROP. Data for 0x10 is never presented (if_en=0). Next imem_addr=32'h0000_0100.
- flush and stall together while IF/ID holds a valid entry -> if_en=0, if_insn=32'h0000_0013 next cycle.
- Wrap and reset: redirect to 32'hFFFF_FFFC then fetch -> next imem_addr=0. Assert reset mid-request -> next cycle all IF/ID outputs at reset values and imem_req=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request outstanding
// and fills the IF/ID register, with a one-entry skid to absorb decode stalls.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN     = 32'h0000_0013,
  parameter int unsigned HART_ST_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_rdy,
  input  logic [31:0]          imem_rd_data,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect_en,
  input  logic [31:0]          redirect_pc,
  input  logic [HART_ST_W-1:0] hart_st,
  output logic                 fetch_busy,
  output logic [31:0]          pc,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_insn,
  output logic                 if_en,
  output logic [HART_ST_W-1:0] if_hart_st
);

  localparam int unsigned   XLEN     = 32;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [XLEN-1:0]       fetch_pc_q, fetch_pc_d;
  logic                  imem_req_q, imem_req_d;
  logic [XLEN-1:0]       imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]       skid_insn_q, skid_insn_d;
  logic [XLEN-1:0]       skid_pc_q, skid_pc_d;
  logic [HART_ST_W-1:0]  skid_hart_q, skid_hart_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       if_pc_q, if_pc_d;
  logic [XLEN-1:0]       if_insn_q, if_insn_d;
  logic                  if_en_q, if_en_d;
  logic [HART_ST_W-1:0]  if_hart_st_q, if_hart_st_d;

  logic                  rsp;
  logic [XLEN-1:0]       redirect_tgt;
  logic                  load_fetch, load_skid, load_bubble;
  logic                  unused_redirect_lsb;

  // A response only counts while our own request is on the bus.
  assign rsp                 = imem_rdy & imem_req_q;
  assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    skid_insn_d  = skid_insn_q;
    skid_pc_d    = skid_pc_q;
    skid_hart_d  = skid_hart_q;
    pc_d         = pc_q;
    if_pc_d      = if_pc_q;
    if_insn_d    = if_insn_q;
    if_en_d      = if_en_q;
    if_hart_st_d = if_hart_st_q;
    load_fetch   = 1'b0;
    load_skid    = 1'b0;
    load_bubble  = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (redirect_en) begin
          fetch_pc_d  = redirect_tgt;
          state_d     = rsp ? S_FETCH : S_DROP;
          load_bubble = !stall;
        end else if (rsp) begin
          if (!stall) begin
            load_fetch = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end else begin
            skid_insn_d = imem_rd_data;
            skid_pc_d   = fetch_pc_q;
            skid_hart_d = hart_st;
            state_d     = S_HOLD;
          end
        end else begin
          load_bubble = !stall;
        end
      end
      S_HOLD: begin
        if (redirect_en) begin
          fetch_pc_d  = redirect_tgt;
          state_d     = S_FETCH;
          load_bubble = !stall;
        end else if (!stall) begin
          load_skid  = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = S_FETCH;
        end
      end
      S_DROP: begin
        if (redirect_en) begin
          fetch_pc_d = redirect_tgt;
        end
        if (rsp) begin
          state_d = S_FETCH;
        end
        load_bubble = !stall;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // flush beats every other IF/ID source, including a held entry.
    if (flush || load_bubble) begin
      if_en_d   = 1'b0;
      if_insn_d = NOP_INSN;
    end else if (load_fetch) begin
      pc_d         = fetch_pc_q;
      if_pc_d      = fetch_pc_q + PC_STEP;
      if_insn_d    = imem_rd_data;
      if_en_d      = 1'b1;
      if_hart_st_d = hart_st;
    end else if (load_skid) begin
      pc_d         = skid_pc_q;
      if_pc_d      = skid_pc_q + PC_STEP;
      if_insn_d    = skid_insn_q;
      if_en_d      = 1'b1;
      if_hart_st_d = skid_hart_q;
    end

    // DROP keeps the stale address on the bus until memory answers it.
    imem_req_d  = (state_d != S_HOLD);
    imem_addr_d = (state_d == S_DROP) ? imem_addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      skid_insn_q  <= NOP_INSN;
      skid_pc_q    <= '0;
      skid_hart_q  <= '0;
      pc_q         <= '0;
      if_pc_q      <= '0;
      if_insn_q    <= NOP_INSN;
      if_en_q      <= 1'b0;
      if_hart_st_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      skid_insn_q  <= skid_insn_d;
      skid_pc_q    <= skid_pc_d;
      skid_hart_q  <= skid_hart_d;
      pc_q         <= pc_d;
      if_pc_q      <= if_pc_d;
      if_insn_q    <= if_insn_d;
      if_en_q      <= if_en_d;
      if_hart_st_q <= if_hart_st_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign fetch_busy = ((state_q == S_FETCH) && !imem_rdy) || (state_q == S_DROP);
  assign pc         = pc_q;
  assign if_pc      = if_pc_q;
  assign if_insn    = if_insn_q;
  assign if_en      = if_en_q;
  assign if_hart_st = if_hart_st_q;

endmodule
